// File: rtl/gb_ppu_pkg.sv
// rtl/gb_ppu_pkg.sv - shared types and constants for the sprite pixel fetch path
package gb_ppu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RD_LO,
        ST_LAT_LO,
        ST_RD_HI,
        ST_LAT_HI,
        ST_MERGE,
        ST_DONE
    } fetch_state_t;

    // OAM attribute byte bit positions
    localparam int ATTR_BG_PRIO = 7;
    localparam int ATTR_Y_FLIP  = 6;
    localparam int ATTR_X_FLIP  = 5;
    localparam int ATTR_DMG_PAL = 4;
    localparam int ATTR_BANK    = 3;

    localparam int SETTLE_CYCLES = 3;
    localparam logic [3:0] IDX_TRANSPARENT = 4'hF;

    typedef struct packed {
        logic [1:0] color;
        logic [3:0] index;
        logic       dmg_pal;
        logic [2:0] cgb_pal;
        logic       bg_prio;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{color: 2'd0, index: IDX_TRANSPARENT,
                                     dmg_pal: 1'b0, cgb_pal: 3'd0, bg_prio: 1'b0};

    // Pixel i lands in bits [2i+1:2i]; leftmost screen pixel is bit 7 of each plane.
    function automatic logic [15:0] row_colors(input logic [7:0] lo, input logic [7:0] hi,
                                               input logic xflip);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (xflip)
                r[2*i +: 2] = {hi[i], lo[i]};
            else
                r[2*i +: 2] = {hi[7-i], lo[7-i]};
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_pixel_fetcher_sprite_pix_fifo.sv
// rtl/sprite_pixel_fetcher_sprite_pix_fifo.sv - 8-slot sprite pixel register with shift and priority merge
module sprite_pix_fifo
    import gb_ppu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 clear,
    input  logic                 isGBC,
    input  logic                 shift_en,
    input  logic                 merge_en,
    input  logic [2*DEPTH-1:0]   merge_color,
    input  logic [3:0]           merge_index,
    input  logic                 merge_dmg_pal,
    input  logic [2:0]           merge_cgb_pal,
    input  logic                 merge_bg_prio,
    output logic [1:0]           pix_color,
    output logic                 pix_dmg_pal,
    output logic [2:0]           pix_cgb_pal,
    output logic                 pix_bg_prio
);

    slot_t slots_q [DEPTH];
    slot_t shifted [DEPTH];
    slot_t merged  [DEPTH];

    // Shift toward slot 0 when the mixer consumed a pixel; the tail refills transparent.
    always_comb begin
        for (int k = 0; k < DEPTH - 1; k++)
            shifted[k] = shift_en ? slots_q[k+1] : slots_q[k];
        shifted[DEPTH-1] = shift_en ? SLOT_EMPTY : slots_q[DEPTH-1];
    end

    // Merge onto the post-shift contents so a concurrent shift keeps the row aligned.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            merged[k] = shifted[k];
            if (merge_en && merge_color[2*k +: 2] != 2'd0 &&
                (shifted[k].color == 2'd0 || (isGBC && merge_index < shifted[k].index))) begin
                merged[k] = '{color: merge_color[2*k +: 2], index: merge_index,
                              dmg_pal: merge_dmg_pal, cgb_pal: merge_cgb_pal,
                              bg_prio: merge_bg_prio};
            end
        end
    end

    // Slot storage, cleared on reset or at the start of each line.
    always_ff @(posedge clk) begin
        if (reset || (ce && clear)) begin
            for (int k = 0; k < DEPTH; k++)
                slots_q[k] <= SLOT_EMPTY;
        end else if (ce) begin
            for (int k = 0; k < DEPTH; k++)
                slots_q[k] <= merged[k];
        end
    end

    assign pix_color   = slots_q[0].color;
    assign pix_dmg_pal = slots_q[0].dmg_pal;
    assign pix_cgb_pal = slots_q[0].cgb_pal;
    assign pix_bg_prio = slots_q[0].bg_prio;

endmodule

// File: rtl/sprite_pixel_fetcher.sv
// rtl/sprite_pixel_fetcher.sv - sprite tile-row fetch FSM feeding the sprite pixel register
module sprite_pixel_fetcher
    import gb_ppu_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        isGBC,
    input  logic        line_start,
    input  logic        sprite_fetch,
    input  logic [10:0] sprite_addr,
    input  logic [7:0]  sprite_attr,
    input  logic [3:0]  sprite_index,
    output logic        sprite_fetch_done,
    output logic [11:0] vram_addr,
    output logic        vram_bank,
    output logic        vram_rd,
    input  logic [7:0]  vram_data,
    input  logic        shift_en,
    output logic [1:0]  pix_color,
    output logic        pix_dmg_pal,
    output logic [2:0]  pix_cgb_pal,
    output logic        pix_bg_prio
);

    fetch_state_t state_q, state_d;
    logic [1:0]   settle_cnt_q;
    logic [10:0]  addr_q;
    logic         plane_q;
    logic [7:0]   attr_q;
    logic [3:0]   index_q;
    logic [7:0]   lo_q, hi_q;
    logic         latch_req;
    logic         merge_en;
    logic         unused_yflip;

    // Y flip is resolved by the evaluator when it forms the row address.
    assign unused_yflip = attr_q[ATTR_Y_FLIP];

    // State register; line_start aborts any fetch without a done pulse.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else if (ce)
            state_q <= line_start ? ST_IDLE : state_d;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d           = state_q;
        vram_rd           = 1'b0;
        sprite_fetch_done = 1'b0;
        merge_en          = 1'b0;
        latch_req         = 1'b0;
        case (state_q)
            ST_IDLE:   if (sprite_fetch) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (!sprite_fetch)
                    state_d = ST_IDLE;
                else if (settle_cnt_q == 2'(SETTLE_CYCLES - 1)) begin
                    latch_req = 1'b1;
                    state_d   = ST_RD_LO;
                end
            end
            ST_RD_LO:  begin vram_rd = 1'b1; state_d = ST_LAT_LO; end
            ST_LAT_LO: state_d = ST_RD_HI;
            ST_RD_HI:  begin vram_rd = 1'b1; state_d = ST_LAT_HI; end
            ST_LAT_HI: state_d = ST_MERGE;
            ST_MERGE:  begin merge_en = 1'b1; state_d = ST_DONE; end
            ST_DONE:   begin sprite_fetch_done = 1'b1; state_d = ST_IDLE; end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Settle counter, request latches, VRAM address plane and tile-byte capture.
    always_ff @(posedge clk) begin
        if (reset || (ce && line_start)) begin
            settle_cnt_q <= '0;
            addr_q       <= '0;
            plane_q      <= 1'b0;
            attr_q       <= '0;
            index_q      <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
        end else if (ce) begin
            if (state_q == ST_IDLE)
                settle_cnt_q <= '0;
            else if (state_q == ST_SETTLE)
                settle_cnt_q <= settle_cnt_q + 2'd1;
            if (latch_req) begin
                addr_q  <= sprite_addr;
                attr_q  <= sprite_attr;
                index_q <= sprite_index;
                plane_q <= 1'b0;
            end
            if (state_q == ST_LAT_LO) begin
                lo_q    <= vram_data;
                plane_q <= 1'b1;
            end
            if (state_q == ST_LAT_HI)
                hi_q <= vram_data;
        end
    end

    assign vram_addr = {addr_q, plane_q};
    assign vram_bank = attr_q[ATTR_BANK] & isGBC;

    sprite_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .ce            (ce),
        .clear         (line_start),
        .isGBC         (isGBC),
        .shift_en      (shift_en),
        .merge_en      (merge_en),
        .merge_color   (row_colors(lo_q, hi_q, attr_q[ATTR_X_FLIP])),
        .merge_index   (index_q),
        .merge_dmg_pal (attr_q[ATTR_DMG_PAL]),
        .merge_cgb_pal (attr_q[2:0]),
        .merge_bg_prio (attr_q[ATTR_BG_PRIO]),
        .pix_color     (pix_color),
        .pix_dmg_pal   (pix_dmg_pal),
        .pix_cgb_pal   (pix_cgb_pal),
        .pix_bg_prio   (pix_bg_prio)
    );

endmodule

// File: tb/tb_sprite_pixel_fetcher.sv
// tb/tb_sprite_pixel_fetcher.sv - self-checking scoreboard bench for sprite_pixel_fetcher
module tb_sprite_pixel_fetcher;

    logic        clk = 1'b0;
    logic        reset, ce, isGBC, line_start, sprite_fetch, shift_en;
    logic [10:0] sprite_addr;
    logic [7:0]  sprite_attr;
    logic [3:0]  sprite_index;
    logic        sprite_fetch_done, vram_bank, vram_rd;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data = 8'h00;
    logic [1:0]  pix_color;
    logic        pix_dmg_pal, pix_bg_prio;
    logic [2:0]  pix_cgb_pal;

    logic [7:0]  vram_lo, vram_hi;
    logic [6:0]  exp_q [$];
    int          n_vec = 0;
    int          n_miss = 0;

    sprite_pixel_fetcher dut (
        .clk(clk), .reset(reset), .ce(ce), .isGBC(isGBC), .line_start(line_start),
        .sprite_fetch(sprite_fetch), .sprite_addr(sprite_addr), .sprite_attr(sprite_attr),
        .sprite_index(sprite_index), .sprite_fetch_done(sprite_fetch_done),
        .vram_addr(vram_addr), .vram_bank(vram_bank), .vram_rd(vram_rd), .vram_data(vram_data),
        .shift_en(shift_en), .pix_color(pix_color), .pix_dmg_pal(pix_dmg_pal),
        .pix_cgb_pal(pix_cgb_pal), .pix_bg_prio(pix_bg_prio)
    );

    always #5 clk = ~clk;

    // Synchronous VRAM: data for the read strobe appears one ce later.
    always @(posedge clk)
        if (ce && vram_rd)
            vram_data <= vram_addr[0] ? vram_hi : vram_lo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_px(input logic [1:0] c, input logic d, input logic [2:0] g, input logic b);
        exp_q.push_back({c, d, g, b});
    endtask

    task automatic push_uniform(input logic [1:0] c, input logic d, input logic [2:0] g, input logic b);
        for (int i = 0; i < 8; i++) push_px(c, d, g, b);
    endtask

    task automatic drain();
        logic [6:0] e;
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            check($sformatf("slot%0d", i), {pix_color, pix_dmg_pal, pix_cgb_pal, pix_bg_prio}, e);
            shift_en = 1'b1;
            @(posedge clk); #1;
            shift_en = 1'b0;
        end
        check("drained_transparent", pix_color, 2'd0);
        check("sb_left", exp_q.size(), 0);
    endtask

    task automatic fetch(input logic [10:0] a, input logic [7:0] attr, input logic [3:0] idx,
                         input logic [7:0] lo, input logic [7:0] hi, input int exp_edges,
                         input bit keep, input bit stall, input int shift_at);
        int  n;
        int  rd;
        bit  got;
        n = 0; rd = 0; got = 0;
        vram_lo = lo; vram_hi = hi;
        sprite_addr = a; sprite_attr = attr; sprite_index = idx;
        sprite_fetch = 1'b1;
        while (!got && n < 40) begin
            ce       = !(stall && (n == 1 || n == 2));
            shift_en = (n == shift_at);
            @(posedge clk); #1;
            n++;
            if (vram_rd) begin
                check("vram_addr", vram_addr, {a, rd[0]});
                check("vram_bank", vram_bank, attr[3] & isGBC);
                rd++;
            end
            if (sprite_fetch_done) got = 1;
        end
        ce = 1'b1;
        shift_en = 1'b0;
        if (!keep) sprite_fetch = 1'b0;
        check("done_seen", got, 1);
        check("latency", n, exp_edges);
        check("rd_count", rd, 2);
        @(posedge clk); #1;
        check("done_one_ce", sprite_fetch_done, 1'b0);
    endtask

    initial begin
        int cnt_rd, cnt_done;
        reset = 1'b1; ce = 1'b1; isGBC = 1'b0; line_start = 1'b0; sprite_fetch = 1'b0;
        shift_en = 1'b0; sprite_addr = '0; sprite_attr = '0; sprite_index = '0;
        vram_lo = '0; vram_hi = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {sprite_fetch_done, vram_addr, vram_bank, vram_rd,
                                pix_color, pix_dmg_pal, pix_cgb_pal, pix_bg_prio}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single DMG fetch
        fetch(11'h123, 8'h00, 4'd0, 8'hF0, 8'hCC, 9, 0, 0, -1);
        push_px(3,0,0,0); push_px(3,0,0,0); push_px(1,0,0,0); push_px(1,0,0,0);
        push_px(2,0,0,0); push_px(2,0,0,0); push_px(0,0,0,0); push_px(0,0,0,0);
        drain();

        // X flip, with two ce-low cycles during settle
        fetch(11'h2AB, 8'h20, 4'd0, 8'hF0, 8'hCC, 11, 0, 1, -1);
        push_px(0,0,0,0); push_px(0,0,0,0); push_px(2,0,0,0); push_px(2,0,0,0);
        push_px(1,0,0,0); push_px(1,0,0,0); push_px(3,0,0,0); push_px(3,0,0,0);
        drain();

        // DMG overlap, back-to-back with sprite_fetch held high
        fetch(11'h055, 8'h10, 4'd0, 8'h55, 8'h00, 9, 1, 0, -1);
        fetch(11'h3FF, 8'h00, 4'd1, 8'h00, 8'hFF, 9, 0, 0, -1);
        for (int i = 0; i < 4; i++) begin
            push_px(2,0,0,0);
            push_px(1,1,0,0);
        end
        drain();

        // GBC priority by index, with bank select and attribute fields
        isGBC = 1'b1;
        fetch(11'h010, 8'h00, 4'd5, 8'hFF, 8'h00, 9, 0, 0, -1);
        fetch(11'h011, 8'h8D, 4'd2, 8'hFF, 8'hFF, 9, 0, 0, -1);
        fetch(11'h012, 8'h00, 4'd3, 8'h00, 8'hFF, 9, 0, 0, -1);
        push_uniform(3, 0, 5, 1);
        drain();

        // Same stimulus in DMG mode: first sprite keeps every slot, bank forced 0
        isGBC = 1'b0;
        fetch(11'h010, 8'h00, 4'd5, 8'hFF, 8'h00, 9, 0, 0, -1);
        fetch(11'h011, 8'h8D, 4'd2, 8'hFF, 8'hFF, 9, 0, 0, -1);
        push_uniform(1, 0, 0, 0);
        drain();

        // Shift coincident with MERGE: merge lands on the shifted contents
        fetch(11'h123, 8'h00, 4'd0, 8'hF0, 8'hCC, 9, 0, 0, -1);
        fetch(11'h124, 8'h00, 4'd1, 8'h00, 8'hFF, 9, 0, 0, 8);
        push_px(3,0,0,0); push_px(1,0,0,0); push_px(1,0,0,0); push_px(2,0,0,0);
        push_px(2,0,0,0); push_px(2,0,0,0); push_px(2,0,0,0); push_px(2,0,0,0);
        drain();

        // line_start during LAT_LO aborts the fetch and clears the register
        fetch(11'h123, 8'h97, 4'd0, 8'hF0, 8'hCC, 9, 0, 0, -1);
        sprite_addr = 11'h222; sprite_attr = 8'h00; sprite_fetch = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("lat_lo_no_rd", vram_rd, 1'b0);
        line_start = 1'b1; sprite_fetch = 1'b0;
        @(posedge clk); #1;
        line_start = 1'b0;
        check("abort_pix", {pix_color, pix_dmg_pal, pix_cgb_pal, pix_bg_prio}, 0);
        check("abort_vram", {vram_addr, vram_rd, vram_bank}, 0);
        cnt_done = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (sprite_fetch_done) cnt_done++;
        end
        check("abort_no_done", cnt_done, 0);
        push_uniform(0, 0, 0, 0);
        drain();

        // sprite_fetch dropped during SETTLE
        sprite_fetch = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sprite_fetch = 1'b0;
        cnt_rd = 0; cnt_done = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (vram_rd) cnt_rd++;
            if (sprite_fetch_done) cnt_done++;
        end
        check("settle_drop_no_rd", cnt_rd, 0);
        check("settle_drop_no_done", cnt_done, 0);

        // Normal fetch still works afterwards
        fetch(11'h077, 8'h00, 4'd0, 8'hF0, 8'hCC, 9, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
